ov5640_init_sequencer: RTL and testbench

OV5640_INIT_SEQUENCER -- requirements
Module: ov5640_init_sequencer

---
 rtl/ov5640_init_sequencer_pkg.sv | 19 +
 rtl/ov5640_init_sequencer_delay.sv | 18 +
 rtl/ov5640_init_sequencer.sv | 110 +++++++++++
 tb/tb_ov5640_init_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ov5640_init_sequencer_pkg.sv
// ov5640_init_sequencer_pkg: sequencer state encoding and camera init-table entry layout
package ov5640_init_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_RD, S_LAT, S_WR, S_WAIT_ACK, S_DLY, S_DONE, S_ERROR
  } state_t;
  localparam int ENTRY_ADDR_MSB = 23;
  localparam int ENTRY_ADDR_LSB = 8;
  localparam int ENTRY_DATA_MSB = 7;
  localparam int ENTRY_DATA_LSB = 0;
  function automatic logic [15:0] entry_addr(input logic [23:0] e);
    return e[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
  endfunction
  function automatic logic [7:0] entry_data(input logic [23:0] e);
    return e[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
  endfunction
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ov5640_init_sequencer_delay.sv
// ov5640_delay_counter: cleared on load, counts while enabled, flags the last cycle of a wait
module ov5640_delay_counter #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else if (i_load) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + W'(1);
  assign o_expire = i_en && (r_cnt == i_limit - W'(1));
endmodule

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks the register table, issuing SCCB writes with power-up/reset waits and retries
module ov5640_init_sequencer
  import ov5640_init_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 24,
  parameter int REG_NUM      = 252,
  parameter int PWRUP_CYCLES = 1_000_000,
  parameter int RST_INDEX    = 1,
  parameter int RST_CYCLES   = 250_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_q,
  output logic                  o_wr_req,
  output logic [15:0]           o_wr_reg_addr,
  output logic [7:0]            o_wr_data,
  input  logic                  i_wr_done,
  input  logic                  i_wr_err,
  output logic                  o_busy,
  output logic                  o_init_done,
  output logic                  o_init_err
);
  localparam int DW = $clog2(max_int(PWRUP_CYCLES, RST_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(REG_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_IDX = ADDR_WIDTH'(RST_INDEX);
  localparam logic [RW-1:0] RETRY_LAST      = RW'(MAX_RETRY - 1);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [RW-1:0] r_retry;
  logic w_expire, w_load, w_idx_clr, w_idx_inc, w_retry_inc, w_retry_clr, w_latch, w_dly_en;
  logic [DW-1:0] w_limit;
  assign w_dly_en = (r_state == S_PWR_WAIT) || (r_state == S_DLY);
  assign w_limit  = (r_state == S_DLY) ? DW'(RST_CYCLES) : DW'(PWRUP_CYCLES);
  ov5640_delay_counter #(.W(DW)) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_en    (w_dly_en),
    .i_limit (w_limit),
    .o_expire(w_expire)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR:
        if (i_start) begin
          w_next    = S_PWR_WAIT;
          w_load    = 1'b1;
          w_idx_clr = 1'b1;
        end
      S_PWR_WAIT: w_next = w_expire ? S_RD : S_PWR_WAIT;
      S_RD:       w_next = S_LAT;
      S_LAT: begin
        w_next  = S_WR;
        w_latch = 1'b1;
      end
      S_WR:       w_next = S_WAIT_ACK;
      S_WAIT_ACK:
        if (i_wr_done && !i_wr_err) begin
          w_retry_clr = 1'b1;
          w_load      = (r_index == RST_IDX);
          w_idx_inc   = (r_index != RST_IDX) && (r_index != LAST);
          w_next      = (r_index == RST_IDX) ? S_DLY : (r_index == LAST) ? S_DONE : S_RD;
        end else if (i_wr_done) begin
          // a NACK replays the same latched entry without re-reading the table
          w_retry_inc = (r_retry < RETRY_LAST);
          w_next      = (r_retry < RETRY_LAST) ? S_WR : S_ERROR;
        end
      S_DLY:
        if (w_expire) begin
          w_idx_inc = (r_index != LAST);
          w_next    = (r_index == LAST) ? S_DONE : S_RD;
        end
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_index       <= '0;
      r_retry       <= '0;
      o_wr_reg_addr <= '0;
      o_wr_data     <= '0;
    end else begin
      r_index <= w_idx_clr ? '0 : w_idx_inc ? r_index + ADDR_WIDTH'(1) : r_index;
      r_retry <= (w_idx_clr || w_retry_clr) ? '0 : w_retry_inc ? r_retry + RW'(1) : r_retry;
      if (w_latch) begin
        o_wr_reg_addr <= entry_addr(i_rom_q[23:0]);
        o_wr_data     <= entry_data(i_rom_q[23:0]);
      end
    end
  assign o_rom_addr  = r_index;
  assign o_wr_req    = (r_state == S_WR);
  assign o_busy      = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign o_init_done = (r_state == S_DONE);
  assign o_init_err  = (r_state == S_ERROR);
endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb_ov5640_init_sequencer: scenario table plus randomized NACK patterns against a write-log reference model
module tb_ov5640_init_sequencer;
  localparam int REG_NUM = 4, PWRUP = 10, RSTC = 5, RST_INDEX = 1, MAX_RETRY = 3;
  typedef struct {
    logic [7:0] nk;
    bit         poke;
    bit         xd;
    bit         xe;
    int         xn;
    int         xi;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, wr_done = 0, wr_err = 0;
  logic [7:0] rom_addr;
  logic [23:0] rom_q;
  logic wr_req, busy, init_done, init_err;
  logic [15:0] wr_reg_addr;
  logic [7:0] wr_data;
  logic [23:0] rom [256];
  int n_chk = 0, n_err = 0;
  logic [23:0] got[$], exp_w[$];
  int got_gap[$], exp_g[$];
  bit plan[$];
  bit m_done, m_err;
  int m_idx;
  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_q <= rom[rom_addr];
  ov5640_init_sequencer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(24), .REG_NUM(REG_NUM), .PWRUP_CYCLES(PWRUP),
    .RST_INDEX(RST_INDEX), .RST_CYCLES(RSTC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .o_rom_addr(rom_addr), .i_rom_q(rom_q),
    .o_wr_req(wr_req), .o_wr_reg_addr(wr_reg_addr), .o_wr_data(wr_data),
    .i_wr_done(wr_done), .i_wr_err(wr_err), .o_busy(busy),
    .o_init_done(init_done), .o_init_err(init_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // expected write log, inter-request gaps and NACK plan derived from per-entry NACK counts
  task automatic model(input int nk[REG_NUM]);
    int gap;
    bit ok;
    gap = PWRUP + 3;
    exp_w.delete(); exp_g.delete(); plan.delete();
    m_done = 0; m_err = 0; m_idx = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      ok = 0;
      for (int a = 0; a < MAX_RETRY && !ok; a++) begin
        exp_w.push_back(rom[i]);
        exp_g.push_back(gap);
        ok = (a >= nk[i]);
        plan.push_back(!ok);
        gap = !ok ? 1 : (i == RST_INDEX ? RSTC + 3 : 3);
      end
      if (!ok) begin
        m_err = 1; m_idx = i;
        return;
      end
    end
    m_done = 1;
  endtask
  task automatic run_seq(input int abort_after, input bit poke);
    int cyc, dly, last_done;
    bit pend, e;
    logic [23:0] cur;
    cyc = 0; dly = 0; last_done = 0; pend = 0; cur = '0;
    got.delete(); got_gap.delete();
    start = 1;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 5);
      wr_done = 0; wr_err = 0;
      if (cyc == 1) begin
        chk("start_clears_done", init_done, 0);
        chk("start_clears_err", init_err, 0);
        chk("busy_after_start", busy, 1);
      end
      if (wr_req) begin
        cur = {wr_reg_addr, wr_data};
        got.push_back(cur);
        got_gap.push_back(cyc - last_done);
        pend = 1;
        dly = $urandom_range(0, 3);
        if (got.size() == abort_after) return;
      end else if (pend) begin
        if (dly > 0) dly--;
        else begin
          chk("hold_addr_data", {wr_reg_addr, wr_data}, cur);
          e = plan.size() > 0 ? plan.pop_front() : 1'b0;
          wr_done = 1; wr_err = e; last_done = cyc; pend = 0;
        end
      end else if (!busy) return;
    end
    n_chk++; n_err++;
    $display("FAIL seq_timeout: still busy after %0d cycles, expected completion", cyc);
  endtask
  task automatic compare_run(input bit xd, input bit xe, input int xn, input int xi);
    chk("init_done", init_done, xd);
    chk("init_err", init_err, xe);
    chk("busy_end", busy, 0);
    chk("num_wr", got.size(), xn);
    if (xe) chk("rom_addr_at_error", rom_addr, xi);
    for (int k = 0; k < exp_w.size() && k < got.size(); k++) begin
      chk($sformatf("wr_entry[%0d]", k), got[k], exp_w[k]);
      chk($sformatf("wr_gap[%0d]", k), got_gap[k], exp_g[k]);
    end
  endtask
  task automatic quiet(input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (wr_req) cnt++;
    end
    chk("no_wr_req_when_stopped", cnt, 0);
    chk("busy_when_stopped", busy, 0);
  endtask
  initial begin
    vec_t vecs[7];
    int nk[REG_NUM];
    vecs[0] = '{8'h00, 1'b0, 1'b1, 1'b0, 4, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 4, 0};
    vecs[2] = '{8'h20, 1'b0, 1'b1, 1'b0, 6, 0};
    vecs[3] = '{8'h30, 1'b0, 1'b0, 1'b1, 5, 2};
    vecs[4] = '{8'h03, 1'b0, 1'b0, 1'b1, 3, 0};
    vecs[5] = '{8'h84, 1'b0, 1'b1, 1'b0, 7, 0};
    vecs[6] = '{8'hC0, 1'b0, 1'b0, 1'b1, 6, 3};
    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_reg_addr", wr_reg_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_init_err", init_err, 0);
    reset = 0;
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < REG_NUM; i++) nk[i] = int'(vecs[v].nk[2*i +: 2]);
      model(nk);
      run_seq(0, vecs[v].poke);
      compare_run(vecs[v].xd, vecs[v].xe, vecs[v].xn, vecs[v].xi);
      if (vecs[v].xe) quiet(10);
    end
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rom[i] = 24'($urandom);
        nk[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      model(nk);
      run_seq(0, 1'($urandom_range(0, 1)));
      compare_run(m_done, m_err, exp_w.size(), m_idx);
    end
    for (int i = 0; i < REG_NUM; i++) nk[i] = 0;
    model(nk);
    run_seq(4, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk("abort_wr_req", wr_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_wr_reg_addr", wr_reg_addr, 0);
    chk("abort_wr_data", wr_data, 0);
    chk("abort_init_done", init_done, 0);
    chk("abort_init_err", init_err, 0);
    reset = 0;
    wr_done = 1;
    @(posedge clk); #1;
    wr_done = 0;
    quiet(10);
    chk("spurious_done_ignored", init_done, 0);
    model(nk);
    run_seq(0, 0);
    compare_run(1, 0, 4, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
